// File: rtl/result_receiver_pkg.sv
// Shared definitions for the result link: frame geometry, lane naming and
// small helpers used by both the receiver and the transmit-side serializer.
package result_receiver_pkg;

    localparam int NUM_WORDS      = 9;
    localparam int BYTES_PER_WORD = 3;
    localparam int FRAME_BYTES    = 27;
    localparam int WORD_W         = 18;
    localparam int PAD_BITS       = 2;

    // Widths of the byte counter (0..27) and word index (0..8).
    localparam int COUNT_W = 5;
    localparam int IDX_W   = 4;

    // Counter values with fixed width for direct comparison.
    localparam logic [COUNT_W-1:0] FRAME_CNT    = 5'd27;
    localparam logic [COUNT_W-1:0] LAST_PAD_CNT = 5'd26;

    // Position of a byte within its word.
    typedef enum logic [1:0] {
        LANE_LO  = 2'd0,
        LANE_HI  = 2'd1,
        LANE_PAD = 2'd2
    } lane_t;

    // A pad byte is malformed when any bit above the carried word bits is set.
    function automatic logic pad_bad(input logic [7:0] b);
        return |b[7:PAD_BITS];
    endfunction

    // Index of the word that the byte at position cnt belongs to.
    function automatic logic [IDX_W-1:0] word_of(input logic [COUNT_W-1:0] cnt);
        logic [COUNT_W-1:0] q;
        q = cnt / 5'd3;
        return q[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/result_receiver_if.sv
// Byte-stream input and reassembled-result outputs of the result receiver.
interface result_receiver_if;
    import result_receiver_pkg::*;

    logic                enable;
    logic                in_valid;
    logic [7:0]          in_data;
    logic [WORD_W-1:0]   C [0:NUM_WORDS-1];
    logic                word_valid;
    logic [IDX_W-1:0]    word_idx;
    logic                done;
    logic                pad_error;
    logic                overrun;

    modport master (
        output enable, in_valid, in_data,
        input  C, word_valid, word_idx, done, pad_error, overrun
    );

    modport slave (
        input  enable, in_valid, in_data,
        output C, word_valid, word_idx, done, pad_error, overrun
    );

endinterface

// File: rtl/result_receiver_word_assembler.sv
// Tracks which lane the next accepted byte fills, stages the low/high bytes
// and presents the completed 18-bit word together with a strobe and a pad
// check in the cycle the pad byte is accepted.
module word_assembler
    import result_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        data_i,
    output logic [WORD_W-1:0] word_o,
    output logic              strobe_o,
    output logic              pad_bad_o
);

    lane_t       lane_q, lane_d;
    logic [15:0] hold_q, hold_d;

    // Next lane and holding-register contents; clearing drops any partial word.
    always_comb begin
        lane_d = lane_q;
        hold_d = hold_q;
        if (clear_i) begin
            lane_d = LANE_LO;
            hold_d = 16'd0;
        end else if (accept_i) begin
            case (lane_q)
                LANE_LO: begin
                    hold_d[7:0] = data_i;
                    lane_d      = LANE_HI;
                end
                LANE_HI: begin
                    hold_d[15:8] = data_i;
                    lane_d       = LANE_PAD;
                end
                LANE_PAD: begin
                    lane_d = LANE_LO;
                end
                default: begin
                    lane_d = LANE_LO;
                    hold_d = 16'd0;
                end
            endcase
        end else begin
            lane_d = lane_q;
            hold_d = hold_q;
        end
    end

    // Lane and holding register state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= LANE_LO;
            hold_q <= 16'd0;
        end else begin
            lane_q <= lane_d;
            hold_q <= hold_d;
        end
    end

    // Completed word is formed from the staged bytes plus the live pad byte.
    always_comb begin
        strobe_o  = accept_i & ~clear_i & (lane_q == LANE_PAD);
        word_o    = {data_i[PAD_BITS-1:0], hold_q};
        pad_bad_o = strobe_o & pad_bad(data_i);
    end

endmodule

// File: rtl/result_receiver.sv
// Receives a 27-byte result frame and reassembles it into nine 18-bit words,
// reporting per-word completion, frame completion and sticky error flags.
module result_receiver
    import result_receiver_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    result_receiver_if.slave  bus
);

    logic                 enable_q;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [WORD_W-1:0]    c_q [0:NUM_WORDS-1];
    logic [WORD_W-1:0]    c_d [0:NUM_WORDS-1];
    logic                 word_valid_q, word_valid_d;
    logic [IDX_W-1:0]     word_idx_q, word_idx_d;
    logic                 done_q, done_d;
    logic                 pad_error_q, pad_error_d;
    logic                 overrun_q, overrun_d;

    logic                 accept_s;
    logic                 en_rise_s;
    logic [IDX_W-1:0]     widx_s;
    logic [WORD_W-1:0]    word_s;
    logic                 strobe_s;
    logic                 pad_bad_s;

    // Byte acceptance and frame-arm edge detection.
    always_comb begin
        accept_s  = bus.enable & bus.in_valid & ~done_q;
        en_rise_s = bus.enable & ~enable_q;
        widx_s    = word_of(count_q);
    end

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (~bus.enable),
        .accept_i  (accept_s),
        .data_i    (bus.in_data),
        .word_o    (word_s),
        .strobe_o  (strobe_s),
        .pad_bad_o (pad_bad_s)
    );

    // Next-state for counter, result words, completion pulse and flags.
    always_comb begin
        count_d      = count_q;
        c_d          = c_q;
        word_valid_d = word_valid_q;
        word_idx_d   = word_idx_q;
        done_d       = done_q;
        pad_error_d  = pad_error_q;
        overrun_d    = overrun_q;
        if (!bus.enable) begin
            // Abort: progress is lost, results and error history are kept.
            count_d      = {COUNT_W{1'b0}};
            done_d       = 1'b0;
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = strobe_s;
            word_idx_d   = strobe_s ? widx_s : word_idx_q;
            done_d       = done_q | (strobe_s & (count_q == LAST_PAD_CNT));
            pad_error_d  = (en_rise_s ? 1'b0 : pad_error_q) | pad_bad_s;
            overrun_d    = (en_rise_s ? 1'b0 : overrun_q) | (bus.in_valid & done_q);
            if (accept_s && (count_q != FRAME_CNT)) begin
                count_d = count_q + 5'd1;
            end else begin
                count_d = count_q;
            end
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (strobe_s && (widx_s == IDX_W'(k))) begin
                    c_d[k] = word_s;
                end else begin
                    c_d[k] = c_q[k];
                end
            end
        end
    end

    // State registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q     <= 1'b0;
            count_q      <= {COUNT_W{1'b0}};
            word_valid_q <= 1'b0;
            word_idx_q   <= {IDX_W{1'b0}};
            done_q       <= 1'b0;
            pad_error_q  <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < NUM_WORDS; k++) begin
                c_q[k] <= {WORD_W{1'b0}};
            end
        end else begin
            enable_q     <= bus.enable;
            count_q      <= count_d;
            word_valid_q <= word_valid_d;
            word_idx_q   <= word_idx_d;
            done_q       <= done_d;
            pad_error_q  <= pad_error_d;
            overrun_q    <= overrun_d;
            for (int k = 0; k < NUM_WORDS; k++) begin
                c_q[k] <= c_d[k];
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.word_valid = word_valid_q;
        bus.word_idx   = word_idx_q;
        bus.done       = done_q;
        bus.pad_error  = pad_error_q;
        bus.overrun    = overrun_q;
        for (int k = 0; k < NUM_WORDS; k++) begin
            bus.C[k] = c_q[k];
        end
    end

endmodule

// File: tb/tb_result_receiver.sv
// Bench for result_receiver: directed frames against a byte-stream model,
// checked every cycle, plus hand-computed spot checks.
module tb_result_receiver;
    import result_receiver_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    result_receiver_if bus();

    result_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int wv_cnt = 0;

    // Model state: what a receiver of the frame must show.
    logic [17:0] m_C [0:8];
    logic [7:0]  m_frame [0:26];
    int          m_count;
    int          m_widx;
    bit          m_done, m_wv, m_pad, m_ovr, m_en_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 9; k++) m_C[k] = 18'd0;
        m_count = 0; m_widx = 0;
        m_done = 0; m_wv = 0; m_pad = 0; m_ovr = 0; m_en_prev = 0;
    endfunction

    // Advance the model by one clock edge with the given inputs.
    function automatic void model_step(input logic en, input logic iv, input logic [7:0] d);
        int k;
        if (!en) begin
            m_count = 0; m_done = 0; m_wv = 0;
        end else begin
            if (!m_en_prev) begin m_pad = 0; m_ovr = 0; end
            m_wv = 0;
            if (iv && m_done) begin
                m_ovr = 1;
            end else if (iv) begin
                m_frame[m_count] = d;
                m_count++;
                if (m_count % 3 == 0) begin
                    k = m_count / 3 - 1;
                    m_C[k] = {m_frame[3*k+2][1:0], m_frame[3*k+1], m_frame[3*k]};
                    m_wv = 1;
                    m_widx = k;
                    if (d[7:2] != 6'd0) m_pad = 1;
                    if (m_count == 27) m_done = 1;
                end
            end
        end
        m_en_prev = en;
    endfunction

    // Compare DUT to model every cycle, then advance the model.
    always @(negedge clk) begin
        if (!reset) model_reset();
        for (int k = 0; k < 9; k++) chk($sformatf("C[%0d]", k), 32'(bus.C[k]), 32'(m_C[k]));
        chk("word_valid", 32'(bus.word_valid), 32'(m_wv));
        chk("word_idx", 32'(bus.word_idx), m_widx);
        chk("done", 32'(bus.done), 32'(m_done));
        chk("pad_error", 32'(bus.pad_error), 32'(m_pad));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        if (bus.word_valid) wv_cnt++;
        if (reset) model_step(bus.enable, bus.in_valid, bus.in_data);
    end

    function automatic logic [17:0] pat(input int sel, input int k);
        case (sel)
            1:       return 18'h10000 + 18'(k);
            2:       return 18'h2A5C0 + 18'(k) * 18'h00111;
            default: return 18'h3FFFF - 18'(k);
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [17:0] w, input int lane);
        case (lane)
            0:       return w[7:0];
            1:       return w[15:8];
            default: return {6'd0, w[17:16]};
        endcase
    endfunction

    task automatic drive(input logic en, input logic iv, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.enable = en;
        bus.in_valid = iv;
        bus.in_data = d;
    endtask

    // Send nbytes of frame sel; the first byte coincides with enable rising.
    task automatic send_frame(input int sel, input int nbytes, input int maxgap, input int badword);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = byte_of(pat(sel, i / 3), i % 3);
            if ((i % 3 == 2) && (i / 3 == badword)) b = 8'hFE;
            if (maxgap > 0 && i > 0) repeat ($urandom_range(0, maxgap)) drive(1'b1, 1'b0, 8'h00);
            drive(1'b1, 1'b1, b);
        end
        drive(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst C0", 32'(bus.C[0]), 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        // Back-to-back frame
        wv_cnt = 0;
        send_frame(1, 27, 0, -1);
        drive(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk("f1 C0", 32'(bus.C[0]), 32'h10000);
        chk("f1 C8", 32'(bus.C[8]), 32'h10008);
        chk("f1 done", 32'(bus.done), 32'd1);
        chk("f1 pad", 32'(bus.pad_error), 32'd0);
        chk("f1 pulses", wv_cnt, 32'd9);

        // Extra bytes after done
        drive(1'b1, 1'b1, 8'hAA);
        drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk("ovr flag", 32'(bus.overrun), 32'd1);
        chk("ovr done", 32'(bus.done), 32'd1);
        chk("ovr C8", 32'(bus.C[8]), 32'h10008);

        // Same frame with gaps
        drive(1'b0, 1'b0, 8'h00);
        send_frame(1, 27, 3, -1);
        drive(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        chk("gap C3", 32'(bus.C[3]), 32'h10003);
        chk("gap ovr clr", 32'(bus.overrun), 32'd0);

        // Bad pad on word 4
        drive(1'b0, 1'b0, 8'h00);
        send_frame(1, 27, 0, 4);
        @(negedge clk);
        chk("pad C4", 32'(bus.C[4]), 32'h20004);
        chk("pad C5", 32'(bus.C[5]), 32'h10005);
        chk("pad flag", 32'(bus.pad_error), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("pad hold", 32'(bus.pad_error), 32'd1);

        // Abort after 14 bytes, then full refill
        send_frame(2, 14, 0, -1);
        drive(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("abort C0", 32'(bus.C[0]), 32'h2A5C0);
        chk("abort C3", 32'(bus.C[3]), 32'h2A8F3);
        chk("abort C4", 32'(bus.C[4]), 32'h20004);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort pad clr", 32'(bus.pad_error), 32'd0);
        send_frame(2, 27, 1, -1);
        @(negedge clk);
        chk("refill C4", 32'(bus.C[4]), 32'h2AA04);
        chk("refill C8", 32'(bus.C[8]), 32'h2AE48);
        chk("refill done", 32'(bus.done), 32'd1);

        // Reset mid-frame
        drive(1'b0, 1'b0, 8'h00);
        send_frame(3, 20, 0, -1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.enable = 1'b0;
        #1;
        chk("mid rst C8", 32'(bus.C[8]), 32'd0);
        chk("mid rst C0", 32'(bus.C[0]), 32'd0);
        chk("mid rst idx", 32'(bus.word_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        send_frame(3, 27, 2, -1);
        @(negedge clk);
        chk("post rst C0", 32'(bus.C[0]), 32'h3FFFF);
        chk("post rst C8", 32'(bus.C[8]), 32'h3FFF7);
        chk("post rst done", 32'(bus.done), 32'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_receiver.md
RESULT_RECEIVER -- requirements
Module: result_receiver

Interface
REQ-001 SHALL have no parameters; all sizes come from the shared package.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  frame arm; low aborts the frame and clears progress.
REQ-005 in_valid  input  1  in_data carries a byte this cycle.
REQ-006 in_data  input  8  received byte.
REQ-007 C  output  9 x 18 (unpacked [0:8])  reassembled result words.
REQ-008 word_valid  output  1  one-cycle pulse: word word_idx just completed.
REQ-009 word_idx  output  4  index 0..8 of the completed word.
REQ-010 done  output  1  all 27 bytes received; held while enable is high.
REQ-011 pad_error  output  1  sticky: a pad byte had nonzero bits [7:2].
REQ-012 overrun  output  1  sticky: a byte arrived while done was high.

Function
REQ-013 Frame SHALL be exactly 27 bytes, word-major, word 0 first; per word: byte0=bits[7:0], byte1=bits[15:8], byte2=pad byte whose bits[1:0]=bits[17:16].
REQ-014 Byte accept SHALL be enable & in_valid & !done; other cycles SHALL not change count or C.
REQ-015 Byte counter count (0..27) SHALL increment by one per accepted byte and SHALL never wrap.
REQ-016 Lane byte0/byte1 SHALL stage into a 16-bit holding register; the word SHALL be written to C[count/3] in the cycle the pad byte is accepted, all 18 bits at once.
REQ-017 C[k] SHALL be visible the cycle after its pad byte is accepted; words not yet received SHALL keep their previous values.
REQ-018 word_valid SHALL pulse high for exactly the cycle after each pad byte is accepted, with word_idx equal to that word's index; otherwise word_valid=0 and word_idx holds.
REQ-019 done SHALL rise in the cycle after the 27th byte is accepted, coincident with word_valid for word 8.
REQ-020 A pad byte with in_data[7:2]!=0 SHALL set pad_error the next cycle; bits[1:0] SHALL still be stored.
REQ-021 in_valid while done & enable SHALL set overrun and SHALL be otherwise ignored.
REQ-022 enable low SHALL, next edge, clear count, done and word_valid; C, pad_error and overrun SHALL hold.
REQ-023 A rising enable SHALL clear pad_error and overrun the next edge and start a fresh frame at byte 0.
REQ-024 A byte presented in the same cycle enable rises SHALL be accepted as byte 0.
REQ-025 enable dropped mid-frame SHALL discard the partial word; C SHALL hold all previously completed words.

Reset
REQ-026 reset low SHALL asynchronously force count=0, holding register=0, all C[k]=0, word_valid=0, word_idx=0, done=0, pad_error=0, overrun=0.
REQ-027 Release SHALL be synchronised to clk; the first accept is allowed on the first edge after release.
REQ-028 Reset asserted mid-frame SHALL take precedence over every other event.

Structure
REQ-029 Shared package SHALL hold NUM_WORDS=9, BYTES_PER_WORD=3, FRAME_BYTES=27, WORD_W=18, PAD_BITS=2.
REQ-030 The package SHALL also hold a lane enum: LANE_LO, LANE_HI, LANE_PAD.
REQ-031 The package SHALL be shared with the transmit-side serializer.
REQ-032 One sub-module, word_assembler, SHALL handle lane tracking, the holding register and pad checking.
REQ-033 word_assembler SHALL emit an 18-bit word plus a strobe; the top level SHALL own count, C, the flags and the handshake.

Verification
REQ-034 Reset, then enable=1 and 27 back-to-back bytes encoding C[k]=0x10000+k -> done rises the cycle after byte 27; C matches; nine word_valid pulses with word_idx 0..8; pad_error=0.
REQ-035 Same frame with in_valid gaps of 0-3 random cycles -> identical C, and done timing relative to the last byte is unchanged.
REQ-036 Word 4 pad byte = 0xFE -> C[4][17:16]=2'b10; pad_error=1 from the next cycle until the next enable rise.
REQ-037 enable dropped after 14 bytes, then a full new frame -> after the drop, C[0..3] are new and C[4..8] are old; done=0; after the refill, all of C is new.
REQ-038 Two extra bytes after done -> overrun=1; C and done are unchanged.
REQ-039 Reset pulsed at byte 20 -> all outputs are 0 immediately; a subsequent full frame decodes correctly.
